// File: rtl/prog_clk_div.sv
// Programmable clock divider: power-of-two legacy select or arbitrary integer
// divisor, with glitch-free divisor changes applied only at period boundaries.
module prog_clk_div #(
  parameter int CNT_W = 16,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_o,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div_o
);

  // state   | meaning
  // ST_IDLE | outputs low, cur_div tracks the requested divisor
  // ST_RUN  | counting through the period of cur_div cycles
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(2);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             clk_o_q, clk_o_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] div_leg;
  logic [CNT_W-1:0] div_req;
  logic [CNT_W-1:0] half_d;
  logic             run_d;

  assign div_leg = ONE << (CNT_W'(sel) + ONE);

  // Divisors 0 and 1 both mean divide-by-one.
  always_comb begin
    div_req = div_leg;
    if (mode) begin
      div_req = (div_val == '0) ? ONE : div_val;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    if (!en) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      cur_div_d = div_req;
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_RUN;
      cnt_d     = '0;
      cur_div_d = div_req;
    end else if (cnt_q == cur_div_q - ONE) begin
      cnt_d     = '0;
      cur_div_d = div_req;
    end else begin
      cnt_d     = cnt_q + ONE;
    end

    // Outputs are decoded from next state so they are plain flops.
    run_d   = (state_d == ST_RUN);
    half_d  = cur_div_d - (cur_div_d >> 1);
    clk_o_d = run_d && (cnt_d < half_d);
    tick_d  = run_d && (cnt_d == cur_div_d - ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_div_q <= DIV_RST;
      clk_o_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      clk_o_q   <= clk_o_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_o     = clk_o_q;
  assign tick      = tick_q;
  assign cur_div_o = cur_div_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: table of steady-state divisor settings
// plus directed sequences for mid-period changes, enable drop and reset.
module tb_prog_clk_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] div_val;
  logic        clk_o;
  logic        tick;
  logic [15:0] cur_div_o;

  int n_pass = 0;
  int n_total = 0;

  prog_clk_div #(.CNT_W(16), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .div_val   (div_val),
    .clk_o     (clk_o),
    .tick      (tick),
    .cur_div_o (cur_div_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] div_val;
    int          exp_div;
    int          exp_high;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform at phase m = k mod div: high for the first 'high' cycles, tick on the last.
  task automatic check_phase(input string tag, input int k, input int div, input int high);
    int m;
    m = k % div;
    check($sformatf("%s k=%0d clk_o", tag, k), int'(clk_o), (m < high) ? 1 : 0);
    check($sformatf("%s k=%0d tick", tag, k), int'(tick), (m == div - 1) ? 1 : 0);
    check($sformatf("%s k=%0d cur_div_o", tag, k), int'(cur_div_o), div);
  endtask

  task automatic check_low(input string tag, input int exp_div);
    check($sformatf("%s clk_o", tag), int'(clk_o), 0);
    check($sformatf("%s tick", tag), int'(tick), 0);
    check($sformatf("%s cur_div_o", tag), int'(cur_div_o), exp_div);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    edge_step();
    edge_step();
    check_low("reset", 2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 16'd9,  2,  1};
    vecs[1]  = '{1'b0, 2'd1, 16'd0,  4,  2};
    vecs[2]  = '{1'b0, 2'd2, 16'd3,  8,  4};
    vecs[3]  = '{1'b0, 2'd3, 16'd5,  16, 8};
    vecs[4]  = '{1'b1, 2'd3, 16'd5,  5,  3};
    vecs[5]  = '{1'b1, 2'd0, 16'd0,  1,  1};
    vecs[6]  = '{1'b1, 2'd1, 16'd1,  1,  1};
    vecs[7]  = '{1'b1, 2'd0, 16'd7,  7,  4};
    vecs[8]  = '{1'b1, 2'd2, 16'd6,  6,  3};
    vecs[9]  = '{1'b1, 2'd0, 16'd3,  3,  2};
    vecs[10] = '{1'b1, 2'd0, 16'd2,  2,  1};

    // Reset asserted together with enable: reset must win.
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0; div_val = 16'd5;
    edge_step();
    edge_step();
    check_low("rst+en", 2);

    for (int v = 0; v < NVEC; v++) begin
      do_reset();
      mode    = vecs[v].mode;
      sel     = vecs[v].sel;
      div_val = vecs[v].div_val;
      en      = 1'b1;
      for (int k = 0; k < 2 * vecs[v].exp_div + 2; k++) begin
        edge_step();
        check_phase($sformatf("vec%0d", v), k, vecs[v].exp_div, vecs[v].exp_high);
      end
    end

    // Divisor change mid-period: 16 -> 4, applied only at the boundary.
    do_reset();
    mode = 1'b0; sel = 2'd3; div_val = 16'd0; en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      edge_step();
      check_phase("chg16", k, 16, 8);
      if (k == 3) sel = 2'd1;
      if (k == 5) sel = 2'd0;
      if (k == 6) sel = 2'd1;
    end
    for (int k = 0; k < 12; k++) begin
      edge_step();
      check_phase("chg4", k, 4, 2);
    end

    // Enable dropped at cnt=5 of divide-by-8, restarted 7 cycles later.
    do_reset();
    mode = 1'b0; sel = 2'd2; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      edge_step();
      check_phase("endrop", k, 8, 4);
    end
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      edge_step();
      check_low($sformatf("idle%0d", i), 8);
    end
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      edge_step();
      check_phase("restart", k, 8, 4);
    end

    // Reset mid-period at cnt=2 of divide-by-5 with enable held.
    do_reset();
    mode = 1'b1; div_val = 16'd5; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_step();
      check_phase("prerst", k, 5, 3);
    end
    rst = 1'b1;
    edge_step();
    check_low("midrst", 2);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edge_step();
      check_phase("postrst", k, 5, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Parametrised, programmable clock divider that generates a divided square wave `clk_o` and a one-cycle period strobe `tick` from the system clock.
- Legacy mode: the divisor is selected as a power of two by a switch field.
- Programmable mode: the divisor is any integer supplied on `div_val`; odd divisors are supported.
- Divisor changes are glitch-free and take effect only at a period boundary.
- There is an enable input with a defined restart phase.
- The block sits between board switches/CSR and the display/timing logic that consumes slow clocks.

Parameters:
- CNT_W, 16: width of the counter, `div_val` and `cur_div_o`. Must be ≥ 2**SEL_W + 1.
- SEL_W, 2: width of `sel`. Legacy divisor = 2^(sel+1), i.e. 2, 4, 8, 16 at the default.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 = idle, outputs low.
- mode  in  1  0 = legacy power-of-two (`sel`), 1 = programmable (`div_val`).
- sel  in  SEL_W  legacy divisor select.
- div_val  in  CNT_W  programmable divisor; 0 and 1 are both treated as 1.
- clk_o  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse in the last cycle of each period, registered.
- cur_div_o  out  CNT_W  divisor currently in effect.

Behaviour:
- Clocking and reset: one clock (`clk`). Reset `rst` is synchronous and active-high. No asynchronous logic; no combinational path from inputs to outputs.
- Requested divisor D_req:
  - mode=0: 1 << (sel+1).
  - mode=1: max(div_val, 1).
- State registers: `run`, `cnt[CNT_W-1:0]`, `cur_div[CNT_W-1:0]`. The outputs are flops loaded from next-state values.
- Output definitions:
  - H = cur_div - (cur_div >> 1), i.e. ceil(cur_div/2).
  - clk_o = run & (cnt < H).
  - tick = run & (cnt == cur_div-1).
  - cur_div_o = cur_div.
- Reset (rst=1 at an edge): `run`=0, `cnt`=0, `cur_div`=2; `clk_o`=0, `tick`=0, `cur_div_o`=2. Reset overrides `en` and a period in progress; there is no completion of the partial period.
- Idle (en=0, rst=0): `run`=0, `cnt`=0, `cur_div`<=D_req every cycle; `clk_o`=0, `tick`=0.
- Start: at the first edge where en=1 and run=0: `run`<=1, `cnt`<=0, `cur_div`<=D_req. `clk_o` is high from that edge, so latency from `en` sampled to `clk_o` rising is 1 edge.
- Running (en=1, run=1):
  - If cnt == cur_div-1: `cnt`<=0 and `cur_div`<=D_req (boundary reload).
  - Otherwise: `cnt`<=cnt+1.
- Duty cycle: high for H cycles, then low for cur_div-H cycles.
  - Even N: exactly 50%.
  - Odd N: high one cycle longer than low.
  - N=1: `clk_o` constantly 1 and `tick` asserted every cycle.
- Divisor changes (`mode`, `sel` or `div_val`) mid-period: no effect until the boundary. The current period always completes at the old length, so there are no runt or stretched pulses. Inputs are sampled only at the boundary edge; toggles between boundaries are ignored.
- en dropped mid-period: the period is abandoned and outputs go 0 at the next edge. Re-enabling restarts at phase 0 (`cnt`=0, `clk_o` high).
- Simultaneous rst and en: rst wins.
- Counter wrap: `cnt` never exceeds cur_div-1; no overflow is possible for any legal `cur_div` ≤ 2^CNT_W-1.

Test Plan:
- Legacy divide-by-2: rst=1 for 2 cycles, then en=1, mode=0, sel=0 → `clk_o` toggles every clk cycle (20 ns period at 10 ns clk), `tick` every 2nd cycle, `cur_div_o`=2.
- Legacy divide-by-16: sel=3 → `clk_o` 8 cycles high / 8 low, `tick` once per 16 cycles, aligned with the last low cycle. Sweep sel=0..3 with a reset between each, giving periods 2/4/8/16.
- Odd divisor: mode=1, div_val=5 → `clk_o` 3 high / 2 low repeating, `tick` every 5th cycle. div_val=0 and div_val=1 → `clk_o` held 1, `tick`=1 every cycle, `cur_div_o`=1.
- Glitch-free change: running div=16, change sel to 1 at cnt=3 → the current period still lasts 16 cycles (8/8), then 4-cycle periods follow. `cur_div_o` changes from 16 to 4 exactly at the boundary edge.
- Enable and restart: drop en at cnt=5 of div=8 → `clk_o`=0 and `tick`=0 next edge. Raise en 7 cycles later → `clk_o`=1 the edge after, first full 4/4 period from phase 0.
- Reset mid-operation: assert rst at cnt=2 of div=5 with en=1 → next edge `clk_o`=0, `tick`=0, `cur_div_o`=2. After deassertion with en=1, `clk_o` rises 1 edge later.
